// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flags #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 winc,
  input  logic                 rinc,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 wfull,
  output logic                 rempty,
  output logic                 walmost_full,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                 DEPTH    = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C  = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_C  = (ADDR_SIZE+1)'(AFULL_TH);
  localparam logic [ADDR_SIZE:0] AEMPTY_C = (ADDR_SIZE+1)'(AEMPTY_TH);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE:0]   rd_ptr;
  logic [ADDR_SIZE:0]   count_q;
  logic                 head_valid;
  logic                 head_valid_next;
  logic [DATA_SIZE-1:0] rdata_q;

  logic                 wr_ok;
  logic                 rd_ok;
  logic                 mem_empty;
  logic                 rd_adv;
  logic                 load_mem;
  logic                 load_bypass;

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  assign wr_addr   = wr_ptr[ADDR_SIZE-1:0];
  assign rd_addr   = rd_ptr[ADDR_SIZE-1:0];
  assign mem_empty = (wr_ptr == rd_ptr);

  // Every flag is a pure decode of registered state, so no request input
  // reaches an output combinationally.
  assign wfull         = (count_q == DEPTH_C);
  assign walmost_full  = (count_q >= AFULL_C);
  assign ralmost_empty = (count_q <= AEMPTY_C);
  assign rempty        = (FWFT != 0) ? ~head_valid : (count_q == '0);
  assign count         = count_q;
  assign rdata         = rdata_q;

  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  // Read-side control. In FWFT mode the head register holds the oldest word,
  // so memory is drained into it whenever it is empty or being popped.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_adv          = 1'b0;
    load_mem        = 1'b0;
    load_bypass     = 1'b0;
    head_valid_next = head_valid;
    if (FWFT == 0) begin
      rd_adv   = rd_ok;
      load_mem = rd_ok;
    end else if (rd_ok) begin
      if (!mem_empty) begin
        load_mem = 1'b1;
        rd_adv   = 1'b1;
      end else if (wr_ok) begin
        // Head popped with nothing queued behind it: the incoming word goes
        // straight to the head; its memory copy is consumed on the same edge.
        load_bypass = 1'b1;
        rd_adv      = 1'b1;
      end else begin
        head_valid_next = 1'b0;
      end
    end else if (!head_valid && !mem_empty) begin
      load_mem        = 1'b1;
      rd_adv          = 1'b1;
      head_valid_next = 1'b1;
    end
  end

  // NOTE: the storage array has no reset; after reset both pointers are equal
  // so old contents can never be read, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      head_valid <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q    <= count_q + (ADDR_SIZE+1)'(wr_ok) - (ADDR_SIZE+1)'(rd_ok);
      head_valid <= head_valid_next;
      if (load_mem) begin
        rdata_q <= mem[rd_addr];
      end else if (load_bypass) begin
        rdata_q <= wdata;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives one stimulus stream into a standard-read and an FWFT instance and
// checks both against scoreboard models of expected contents and flags.
module tb_sync_fifo_flags;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wdata;
  logic          winc;
  logic          rinc;
  logic          err_clr;

  logic [DW-1:0] rdata0, rdata1;
  logic          wfull0, wfull1, rempty0, rempty1;
  logic          afull0, afull1, aempty0, aempty1;
  logic [AW:0]   count0, count1;
  logic          ovf0, ovf1, udf0, udf1;

  int checks = 0;
  int errors = 0;

  // Scoreboards: words expected to come out of each instance, in order.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] m_rdata0;
  logic          m_hv1;
  logic          m_ovf0, m_udf0, m_ovf1, m_udf1;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .walmost_full(afull0),
    .ralmost_empty(aempty0), .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_flags #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(afull1),
    .ralmost_empty(aempty1), .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n0 = q0.size();
    int n1 = q1.size();
    check("std_count",   32'(count0),  32'(n0));
    check("std_wfull",   32'(wfull0),  32'(n0 == DEPTH));
    check("std_rempty",  32'(rempty0), 32'(n0 == 0));
    check("std_afull",   32'(afull0),  32'(n0 >= 12));
    check("std_aempty",  32'(aempty0), 32'(n0 <= 2));
    check("std_ovf",     32'(ovf0),    32'(m_ovf0));
    check("std_udf",     32'(udf0),    32'(m_udf0));
    check("std_rdata",   32'(rdata0),  32'(m_rdata0));
    check("fwft_count",  32'(count1),  32'(n1));
    check("fwft_wfull",  32'(wfull1),  32'(n1 == DEPTH));
    check("fwft_rempty", 32'(rempty1), 32'(!m_hv1));
    check("fwft_afull",  32'(afull1),  32'(n1 >= 12));
    check("fwft_aempty", 32'(aempty1), 32'(n1 <= 2));
    check("fwft_ovf",    32'(ovf1),    32'(m_ovf1));
    check("fwft_udf",    32'(udf1),    32'(m_udf1));
    if (m_hv1) check("fwft_rdata", 32'(rdata1), 32'(q1[0]));
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_rdata0 = '0;
    m_hv1    = 1'b0;
    m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;
  endtask

  task automatic reset_checks();
    model_reset();
    check_all();
    check("fwft_rdata_rst", 32'(rdata1), 32'h0);
  endtask

  // One clock of stimulus; models are advanced from pre-edge state.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    int  n0 = q0.size();
    int  n1 = q1.size();
    logic wr0, rd0, wr1, rd1;
    winc = w; wdata = d; rinc = r; err_clr = c;
    @(posedge clk);
    #1;
    wr0 = w && (n0 < DEPTH);
    rd0 = r && (n0 > 0);
    if (w && n0 == DEPTH) m_ovf0 = 1'b1; else if (c) m_ovf0 = 1'b0;
    if (r && n0 == 0)     m_udf0 = 1'b1; else if (c) m_udf0 = 1'b0;
    if (rd0) m_rdata0 = q0.pop_front();
    if (wr0) q0.push_back(d);
    wr1 = w && (n1 < DEPTH);
    rd1 = r && m_hv1;
    if (w && n1 == DEPTH) m_ovf1 = 1'b1; else if (c) m_ovf1 = 1'b0;
    if (r && !m_hv1)      m_udf1 = 1'b1; else if (c) m_udf1 = 1'b0;
    if (rd1) void'(q1.pop_front());
    if (wr1) q1.push_back(d);
    if (rd1)         m_hv1 = (n1 - 1 + int'(wr1)) > 0;
    else if (!m_hv1) m_hv1 = n1 > 0;
    check_all();
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;
    #3;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // FWFT fall-through latency and bypass on read+write at count 1.
    step(1'b1, 16'hA5A5, 1'b0, 1'b0);
    check("fwft_rempty_n", 32'(rempty1), 32'h1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("fwft_head_a5", 32'(rdata1), 32'hA5A5);
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    check("fwft_head_5a", 32'(rdata1), 32'h5A5A);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Fill to full plus one rejected write.
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("std_ovf_set", 32'(ovf0), 32'h1);

    // Drain plus one rejected read.
    for (int i = 1; i <= 16; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("std_last_word", 32'(rdata0), 32'h0010);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("std_udf_set", 32'(udf0), 32'h1);

    // Simultaneous read/write at full, then clear errors.
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hBAD0, 1'b1, 1'b0);
    check("std_full_rw_cnt", 32'(count0), 32'd15);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("std_ovf_clr", 32'(ovf0), 32'h0);

    // Wrap-around at count 8 with an incrementing pattern.
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
    check("wrap_count", 32'(count0), 32'd8);

    // Asynchronous reset mid-stream at count 9.
    step(1'b1, 16'h0777, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count0), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("fwft_post_rst", 32'(rdata1), 32'hBEEF);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("std_post_rst", 32'(rdata0), 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
